// File: rtl/ov7670_cfg_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : ov7670_cfg_sequencer
//  Description : Walks a {reg, value} table held in an external synchronous
//                ROM and issues one I2C/SCCB write per entry to an
//                i2c_master write port. In-table delay entries pause the walk.
//                NACKed writes are retried a bounded number of times.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    i_clk, i_rstn       clock, asynchronous active-low reset
//    i_start             1-cycle pulse: run the table from entry 0 (ignored while busy)
//    o_rom_addr          table index; i_rom_data is valid one cycle after it changes
//    i_rom_data          {reg[15:8], val[7:0]}; 16'hFFFF = end, 16'hF0nn = delay nn ms
//    o_wr                write request to i2c_master (held until i_i2c_busy seen)
//    o_slave_addr        constant 7-bit SCCB slave address
//    o_reg_addr, o_wdata register address / data of the current entry
//    i_i2c_busy          i2c_master busy
//    i_nack_*            i2c_master NACK flags (slave address / register / data)
//    o_busy              sequence in progress
//    o_done, o_error     sticky completion / abort flags, cleared by i_start
//    o_err_index         index of the entry that aborted the sequence
// ============================================================================
module ov7670_cfg_sequencer #(
    parameter int         T_CLK      = 10,
    parameter logic [6:0] SLAVE_ADDR = 7'h21,
    parameter int         ADDR_W     = 8,
    parameter int         MAX_RETRY  = 3
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_start,
    output logic [ADDR_W-1:0] o_rom_addr,
    input  logic [15:0]       i_rom_data,
    output logic              o_wr,
    output logic [6:0]        o_slave_addr,
    output logic [7:0]        o_reg_addr,
    output logic [7:0]        o_wdata,
    input  logic              i_i2c_busy,
    input  logic              i_nack_slave,
    input  logic              i_nack_addr,
    input  logic              i_nack_data,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_error,
    output logic [ADDR_W-1:0] o_err_index
);

    localparam int CYC_PER_MS = 1_000_000 / T_CLK;
    localparam int CYC_W      = (CYC_PER_MS > 2) ? $clog2(CYC_PER_MS) : 2;
    localparam int RETRY_W    = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    // The first millisecond of a delay starts two cycles in, so the
    // fetch/decode cycles around the delay entry do not push the next write
    // noticeably past nn ms after the sequence reached the delay.
    localparam logic [CYC_W-1:0] C_DLY_TRIM = CYC_W'(2);
    localparam logic [CYC_W-1:0] C_CYC_LAST = CYC_W'(CYC_PER_MS - 1);

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_FETCH    = 4'd1;
    localparam logic [3:0] S_DECODE   = 4'd2;
    localparam logic [3:0] S_ISSUE    = 4'd3;
    localparam logic [3:0] S_WAIT_ACC = 4'd4;
    localparam logic [3:0] S_WAIT_END = 4'd5;
    localparam logic [3:0] S_CHECK    = 4'd6;
    localparam logic [3:0] S_DELAY    = 4'd7;
    localparam logic [3:0] S_FINISH   = 4'd8;

    logic [3:0]         state_q,     state_d;
    logic [ADDR_W-1:0]  rom_addr_q,  rom_addr_d;
    logic [7:0]         reg_addr_q,  reg_addr_d;
    logic [7:0]         wdata_q,     wdata_d;
    logic               wr_q,        wr_d;
    logic               busy_q,      busy_d;
    logic               done_q,      done_d;
    logic               error_q,     error_d;
    logic [ADDR_W-1:0]  err_index_q, err_index_d;
    logic [RETRY_W-1:0] retry_q,     retry_d;
    logic               nack_seen_q, nack_seen_d;
    logic [7:0]         ms_cnt_q,    ms_cnt_d;
    logic [CYC_W-1:0]   cyc_cnt_q,   cyc_cnt_d;

    logic w_nack_any;
    logic w_last_entry;

    assign w_nack_any   = i_nack_slave | i_nack_addr | i_nack_data;
    // The last table slot ends the sequence even without a terminator.
    assign w_last_entry = (rom_addr_q == {ADDR_W{1'b1}});

    always_comb begin
        state_d     = state_q;
        rom_addr_d  = rom_addr_q;
        reg_addr_d  = reg_addr_q;
        wdata_d     = wdata_q;
        busy_d      = busy_q;
        done_d      = done_q;
        error_d     = error_q;
        err_index_d = err_index_q;
        retry_d     = retry_q;
        nack_seen_d = nack_seen_q;
        ms_cnt_d    = ms_cnt_q;
        cyc_cnt_d   = cyc_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    rom_addr_d = '0;
                    done_d     = 1'b0;
                    error_d    = 1'b0;
                    retry_d    = '0;
                    busy_d     = 1'b1;
                    state_d    = S_FETCH;
                end
            end

            S_FETCH: begin
                state_d = S_DECODE;
            end

            S_DECODE: begin
                if (i_rom_data == 16'hFFFF) begin
                    state_d = S_FINISH;
                end else if (i_rom_data[15:8] == 8'hF0) begin
                    ms_cnt_d  = i_rom_data[7:0];
                    cyc_cnt_d = C_DLY_TRIM;
                    state_d   = S_DELAY;
                end else begin
                    reg_addr_d  = i_rom_data[15:8];
                    wdata_d     = i_rom_data[7:0];
                    nack_seen_d = 1'b0;
                    state_d     = S_ISSUE;
                end
            end

            S_DELAY: begin
                if (ms_cnt_q == 8'd0) begin
                    if (w_last_entry) begin
                        state_d = S_FINISH;
                    end else begin
                        rom_addr_d = rom_addr_q + ADDR_W'(1);
                        state_d    = S_FETCH;
                    end
                end else if (cyc_cnt_q == C_CYC_LAST) begin
                    cyc_cnt_d = '0;
                    ms_cnt_d  = ms_cnt_q - 8'd1;
                end else begin
                    cyc_cnt_d = cyc_cnt_q + CYC_W'(1);
                end
            end

            S_ISSUE: begin
                if (i_i2c_busy) begin
                    nack_seen_d = nack_seen_q | w_nack_any;
                    state_d     = S_WAIT_ACC;
                end
            end

            S_WAIT_ACC: begin
                if (i_i2c_busy) begin
                    nack_seen_d = nack_seen_q | w_nack_any;
                end
                state_d = S_WAIT_END;
            end

            // NACK flags are only trusted while busy: the master clears them
            // in the same cycle busy falls.
            S_WAIT_END: begin
                if (i_i2c_busy) begin
                    nack_seen_d = nack_seen_q | w_nack_any;
                end else begin
                    state_d = S_CHECK;
                end
            end

            S_CHECK: begin
                if (!nack_seen_q) begin
                    retry_d = '0;
                    if (w_last_entry) begin
                        state_d = S_FINISH;
                    end else begin
                        rom_addr_d = rom_addr_q + ADDR_W'(1);
                        state_d    = S_FETCH;
                    end
                end else if (retry_q < RETRY_W'(MAX_RETRY)) begin
                    // Re-issue from the latched reg/value; the ROM is not re-read.
                    retry_d     = retry_q + RETRY_W'(1);
                    nack_seen_d = 1'b0;
                    state_d     = S_ISSUE;
                end else begin
                    error_d     = 1'b1;
                    err_index_d = rom_addr_q;
                    busy_d      = 1'b0;
                    state_d     = S_IDLE;
                end
            end

            S_FINISH: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // The write request is asserted for exactly the cycles spent in ISSUE.
        wr_d = (state_d == S_ISSUE);
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q     <= S_IDLE;
            rom_addr_q  <= '0;
            reg_addr_q  <= '0;
            wdata_q     <= '0;
            wr_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            err_index_q <= '0;
            retry_q     <= '0;
            nack_seen_q <= 1'b0;
            ms_cnt_q    <= '0;
            cyc_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            rom_addr_q  <= rom_addr_d;
            reg_addr_q  <= reg_addr_d;
            wdata_q     <= wdata_d;
            wr_q        <= wr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            err_index_q <= err_index_d;
            retry_q     <= retry_d;
            nack_seen_q <= nack_seen_d;
            ms_cnt_q    <= ms_cnt_d;
            cyc_cnt_q   <= cyc_cnt_d;
        end
    end

    assign o_rom_addr   = rom_addr_q;
    assign o_wr         = wr_q;
    assign o_slave_addr = SLAVE_ADDR;
    assign o_reg_addr   = reg_addr_q;
    assign o_wdata      = wdata_q;
    assign o_busy       = busy_q;
    assign o_done       = done_q;
    assign o_error      = error_q;
    assign o_err_index  = err_index_q;

endmodule
`default_nettype wire

// File: tb/tb_ov7670_cfg_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ov7670_cfg_sequencer
//  Description : Scoreboard bench for ov7670_cfg_sequencer. Expected writes
//                are queued by the stimulus; a monitor pops one per rising
//                o_wr. A behavioural i2c_master answers requests and can
//                NACK chosen registers or stall after reset.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ov7670_cfg_sequencer;

    localparam int ADDR_W = 4;
    localparam int T_CLK  = 10000;               // 100 cycles per ms
    localparam int CYC_MS = 1_000_000 / T_CLK;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              i_start = 1'b0;
    logic [ADDR_W-1:0] o_rom_addr;
    logic [15:0]       rom_data = 16'h0000;
    logic              o_wr;
    logic [6:0]        o_slave_addr;
    logic [7:0]        o_reg_addr;
    logic [7:0]        o_wdata;
    logic              i2c_busy = 1'b0;
    logic              nack_s = 1'b0;
    logic              nack_a = 1'b0;
    logic              nack_d = 1'b0;
    logic              o_busy;
    logic              o_done;
    logic              o_error;
    logic [ADDR_W-1:0] o_err_index;

    ov7670_cfg_sequencer #(
        .T_CLK      (T_CLK),
        .SLAVE_ADDR (7'h21),
        .ADDR_W     (ADDR_W),
        .MAX_RETRY  (3)
    ) dut (
        .i_clk        (clk),
        .i_rstn       (rstn),
        .i_start      (i_start),
        .o_rom_addr   (o_rom_addr),
        .i_rom_data   (rom_data),
        .o_wr         (o_wr),
        .o_slave_addr (o_slave_addr),
        .o_reg_addr   (o_reg_addr),
        .o_wdata      (o_wdata),
        .i_i2c_busy   (i2c_busy),
        .i_nack_slave (nack_s),
        .i_nack_addr  (nack_a),
        .i_nack_data  (nack_d),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_error      (o_error),
        .o_err_index  (o_err_index)
    );

    always #5 clk = ~clk;

    // Synchronous ROM: one cycle of latency.
    logic [15:0] rom [2**ADDR_W];
    always @(posedge clk) rom_data <= rom[o_rom_addr];

    int          n_vec  = 0;
    int          n_fail = 0;
    int          n_wr   = 0;
    logic [15:0] exp_q[$];

    int          hold_left = 0;
    int          nack_left = 0;
    logic [7:0]  nack_reg  = 8'h00;
    int          nack_kind = 0;   // 0 data, 1 register address, 2 slave address

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_vec++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic load_table(input logic [15:0] e0, e1, e2, e3);
        for (int i = 0; i < 2**ADDR_W; i++) rom[i] = 16'hFFFF;
        rom[0] = e0; rom[1] = e1; rom[2] = e2; rom[3] = e3;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 i_start = 1'b1;
        @(posedge clk); #1 i_start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (o_busy && n < 5000) begin @(negedge clk); n++; end
        if (o_busy) check(name, 32'd0, 32'd1);
    endtask

    task automatic wait_wr(input string name);
        int n = 0;
        @(negedge clk);
        while (!o_wr && n < 2000) begin @(negedge clk); n++; end
        if (!o_wr) check(name, 32'd0, 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clk); rstn = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
    endtask

    // Behavioural i2c_master: accepts o_wr when idle, stays busy 20 cycles,
    // optionally raises one NACK flag mid-transfer, clears flags as busy falls.
    initial begin
        logic do_nack;
        forever begin
            @(posedge clk); #1;
            if (!rstn) begin
                i2c_busy = 1'b0; nack_s = 1'b0; nack_a = 1'b0; nack_d = 1'b0;
            end else if (hold_left > 0) begin
                hold_left--;
            end else if (o_wr && !i2c_busy) begin
                do_nack = (nack_left > 0) && (o_reg_addr == nack_reg);
                if (do_nack) nack_left--;
                i2c_busy = 1'b1;
                for (int c = 0; c < 20 && rstn; c++) begin
                    @(posedge clk); #1;
                    if (c == 8 && do_nack) begin
                        if (nack_kind == 0)      nack_d = 1'b1;
                        else if (nack_kind == 1) nack_a = 1'b1;
                        else                     nack_s = 1'b1;
                    end
                end
                i2c_busy = 1'b0; nack_s = 1'b0; nack_a = 1'b0; nack_d = 1'b0;
            end
        end
    end

    // Monitor: every rising o_wr is one write; compare against the scoreboard.
    initial begin
        logic        prev;
        logic [15:0] exp;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (o_wr && !prev) begin
                n_wr++;
                if (exp_q.size() == 0) begin
                    check("unexpected_write", {o_reg_addr, o_wdata}, 32'hDEAD);
                end else begin
                    exp = exp_q.pop_front();
                    check("write_reg_val", {o_reg_addr, o_wdata}, exp);
                    check("write_slave", o_slave_addr, 7'h21);
                end
            end
            prev = o_wr;
        end
    end

    initial begin
        int wr0;
        int cnt;

        // ---- reset values ----
        load_table(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        repeat (3) @(negedge clk);
        check("rst_wr",        o_wr,        0);
        check("rst_busy",      o_busy,      0);
        check("rst_done",      o_done,      0);
        check("rst_error",     o_error,     0);
        check("rst_err_index", o_err_index, 0);
        check("rst_rom_addr",  o_rom_addr,  0);
        check("rst_slave",     o_slave_addr, 7'h21);
        check("rst_reg",       o_reg_addr,  0);
        check("rst_wdata",     o_wdata,     0);
        rstn = 1'b1;

        // ---- T1: two writes then terminator ----
        load_table(16'h1280, 16'h1101, 16'hFFFF, 16'hFFFF);
        exp_q.push_back(16'h1280); exp_q.push_back(16'h1101);
        wr0 = n_wr;
        pulse_start();
        check("t1_busy_after_start", o_busy, 1);
        wait_idle("t1_timeout");
        check("t1_done",   o_done,  1);
        check("t1_error",  o_error, 0);
        check("t1_writes", n_wr - wr0, 2);
        check("t1_queue",  exp_q.size(), 0);

        // ---- T2: 5 ms delay entry before the write ----
        load_table(16'hF005, 16'h3A04, 16'hFFFF, 16'hFFFF);
        exp_q.push_back(16'h3A04);
        @(posedge clk); #1 i_start = 1'b1;
        @(posedge clk); #1 i_start = 1'b0;
        cnt = 0;
        while (!o_wr && cnt < 2000) begin @(posedge clk); #1; cnt++; end
        check_range("t2_delay_cycles", cnt, 5 * CYC_MS - 3, 5 * CYC_MS + 3);
        wait_idle("t2_timeout");
        check("t2_done",  o_done, 1);
        check("t2_queue", exp_q.size(), 0);

        // ---- T3: data NACK twice on entry 1, then ACK ----
        load_table(16'h1280, 16'h1101, 16'hFFFF, 16'hFFFF);
        nack_reg = 8'h11; nack_left = 2; nack_kind = 0;
        exp_q.push_back(16'h1280);
        repeat (3) exp_q.push_back(16'h1101);
        wr0 = n_wr;
        pulse_start();
        wait_idle("t3_timeout");
        check("t3_done",   o_done,  1);
        check("t3_error",  o_error, 0);
        check("t3_writes", n_wr - wr0, 4);
        check("t3_queue",  exp_q.size(), 0);

        // ---- T4: address NACK forever -> abort after 3 retries ----
        load_table(16'h4455, 16'h6677, 16'hFFFF, 16'hFFFF);
        nack_reg = 8'h44; nack_left = 100; nack_kind = 1;
        repeat (4) exp_q.push_back(16'h4455);
        wr0 = n_wr;
        pulse_start();
        wait_idle("t4_timeout");
        check("t4_error",     o_error, 1);
        check("t4_err_index", o_err_index, 0);
        check("t4_done",      o_done, 0);
        check("t4_writes",    n_wr - wr0, 4);
        check("t4_queue",     exp_q.size(), 0);
        nack_left = 0;

        // ---- T5a: i_start during a sequence is ignored ----
        load_table(16'h1280, 16'h1101, 16'hFFFF, 16'hFFFF);
        exp_q.push_back(16'h1280); exp_q.push_back(16'h1101);
        wr0 = n_wr;
        pulse_start();
        check("t5_error_cleared", o_error, 0);
        wait_wr("t5_wr_timeout");
        pulse_start();
        check("t5_busy_kept", o_busy, 1);
        wait_idle("t5_timeout");
        check("t5_done",   o_done, 1);
        check("t5_writes", n_wr - wr0, 2);

        // ---- T5b: reset while o_wr is high ----
        exp_q.push_back(16'h1280);
        pulse_start();
        wait_wr("t5b_wr_timeout");
        #2 rstn = 1'b0;
        #1;
        check("t5b_wr_async",   o_wr,   0);
        check("t5b_busy_async", o_busy, 0);
        check("t5b_done_async", o_done, 0);
        @(negedge clk); @(negedge clk); rstn = 1'b1;
        check("t5b_rom_addr", o_rom_addr, 0);
        exp_q.push_back(16'h1280); exp_q.push_back(16'h1101);
        pulse_start();
        wait_idle("t5b_timeout");
        check("t5b_done",  o_done, 1);
        check("t5b_queue", exp_q.size(), 0);

        // ---- T6: master stalls 200 cycles after reset ----
        load_table(16'h2233, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        hold_left = 200;
        do_reset();
        exp_q.push_back(16'h2233);
        wr0 = n_wr;
        pulse_start();
        repeat (100) @(negedge clk);
        check("t6_wr_held", o_wr, 1);
        check("t6_one_rise", n_wr - wr0, 1);
        wait_idle("t6_timeout");
        check("t6_done",   o_done, 1);
        check("t6_writes", n_wr - wr0, 1);
        check("t6_queue",  exp_q.size(), 0);

        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
